// File: rtl/batrider_snd_rom_arb.sv
// Sound-side SDRAM read arbiter: one-word cache per requester (Z80, OKI0, OKI1), misses fetched one at a time.
// Build option BATRIDER_SNDARB_Z80PRIO_EN: Z80 always wins, PCM0/PCM1 round-robin between themselves.
module batrider_snd_rom_arb #(
    parameter int              AW        = 22,
    parameter logic [AW-1:0]   Z80_OFFS  = 22'h000000,
    parameter logic [AW-1:0]   PCM0_OFFS = 22'h020000,
    parameter logic [AW-1:0]   PCM1_OFFS = 22'h120000
) (
    input  logic          CLK96,
    input  logic          RESET96,
    input  logic          Z80_CS,
    input  logic [17:0]   Z80_ADDR,
    output logic          Z80_OK,
    output logic [7:0]    Z80_DOUT,
    input  logic          PCM0_CS,
    input  logic [20:0]   PCM0_ADDR,
    output logic          PCM0_OK,
    output logic [7:0]    PCM0_DOUT,
    input  logic          PCM1_CS,
    input  logic [20:0]   PCM1_ADDR,
    output logic          PCM1_OK,
    output logic [7:0]    PCM1_DOUT,
    output logic          SDR_CS,
    output logic [AW-1:0] SDR_ADDR,
    input  logic          SDR_OK,
    input  logic [15:0]   SDR_DATA
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

    state_t        state, state_n;
    logic [1:0]    rr, rr_n, rr_adv, gnt, gnt_n, pick;
    logic [19:0]   gaddr, gaddr_n;
    logic          sdr_cs_n, fill, pick_any;
    logic [AW-1:0] sdr_addr_n;
    logic [2:0]    cs, hit, pend, valid;
    logic [19:0]   tag  [3];
    logic [15:0]   word [3];
    logic [19:0]   wa   [3];
    logic [AW-1:0] offs [3];

    assign cs      = {PCM1_CS, PCM0_CS, Z80_CS};
    assign wa[0]   = {3'b000, Z80_ADDR[17:1]};
    assign wa[1]   = PCM0_ADDR[20:1];
    assign wa[2]   = PCM1_ADDR[20:1];
    assign offs[0] = Z80_OFFS;
    assign offs[1] = PCM0_OFFS;
    assign offs[2] = PCM1_OFFS;

    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < 3; i++)
            hit[i] = cs[i] & valid[i] & (tag[i] == wa[i]);
    end

    assign pend      = cs & ~hit;
    assign Z80_OK    = hit[0];
    assign PCM0_OK   = hit[1];
    assign PCM1_OK   = hit[2];
    assign Z80_DOUT  = Z80_ADDR[0]  ? word[0][15:8] : word[0][7:0];
    assign PCM0_DOUT = PCM0_ADDR[0] ? word[1][15:8] : word[1][7:0];
    assign PCM1_DOUT = PCM1_ADDR[0] ? word[2][15:8] : word[2][7:0];

    assign pick_any = |pend;

`ifdef BATRIDER_SNDARB_Z80PRIO_EN
    // rr only ever names a PCM index here; the reset value (Z80) behaves as PCM0.
    always_comb begin
        pick = 2'd0;
        if (pend[0])         pick = 2'd0;
        else if (rr == 2'd2) pick = pend[2] ? 2'd2 : 2'd1;
        else                 pick = pend[1] ? 2'd1 : 2'd2;
    end
    assign rr_adv = (gnt == 2'd1) ? 2'd2 : (gnt == 2'd2) ? 2'd1 : rr;
`else
    always_comb begin
        pick = 2'd0;
        case (rr)
            2'd1:    pick = pend[1] ? 2'd1 : pend[2] ? 2'd2 : 2'd0;
            2'd2:    pick = pend[2] ? 2'd2 : pend[0] ? 2'd0 : 2'd1;
            default: pick = pend[0] ? 2'd0 : pend[1] ? 2'd1 : 2'd2;
        endcase
    end
    assign rr_adv = (gnt == 2'd2) ? 2'd0 : gnt + 2'd1;
`endif

    always_comb begin
        state_n    = state;
        sdr_cs_n   = SDR_CS;
        sdr_addr_n = SDR_ADDR;
        gnt_n      = gnt;
        gaddr_n    = gaddr;
        rr_n       = rr;
        fill       = 1'b0;
        case (state)
            IDLE: if (pick_any) begin
                gnt_n      = pick;
                gaddr_n    = wa[pick];
                sdr_addr_n = offs[pick] + AW'(wa[pick]);
                sdr_cs_n   = 1'b1;
                state_n    = ISSUE;
            end
            // Acks seen here may belong to a previous owner of the slot.
            ISSUE: state_n = WAIT_ACK;
            WAIT_ACK: if (SDR_OK) begin
                fill     = 1'b1;
                sdr_cs_n = 1'b0;
                rr_n     = rr_adv;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            state    <= IDLE;
            SDR_CS   <= 1'b0;
            SDR_ADDR <= '0;
            gnt      <= 2'd0;
            gaddr    <= '0;
            rr       <= 2'd0;
        end else begin
            state    <= state_n;
            SDR_CS   <= sdr_cs_n;
            SDR_ADDR <= sdr_addr_n;
            gnt      <= gnt_n;
            gaddr    <= gaddr_n;
            rr       <= rr_n;
        end
    end

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            valid <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                tag[i]  <= '0;
                word[i] <= '0;
            end
        end else if (fill) begin
            word[gnt]  <= SDR_DATA;
            tag[gnt]   <= gaddr;
            valid[gnt] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_batrider_snd_rom_arb.sv
// Directed bench for batrider_snd_rom_arb: hand-computed fills, hits, arbitration order and reset behaviour.
// Define BATRIDER_SNDARB_Z80PRIO_EN to check the Z80-priority grant order instead.
module tb_batrider_snd_rom_arb;

    logic        CLK96, RESET96;
    logic        Z80_CS, Z80_OK, PCM0_CS, PCM0_OK, PCM1_CS, PCM1_OK;
    logic [17:0] Z80_ADDR;
    logic [20:0] PCM0_ADDR, PCM1_ADDR;
    logic [7:0]  Z80_DOUT, PCM0_DOUT, PCM1_DOUT;
    logic        SDR_CS, SDR_OK;
    logic [21:0] SDR_ADDR;
    logic [15:0] SDR_DATA;

    int n_chk  = 0;
    int n_pass = 0;

    batrider_snd_rom_arb #(
        .AW(22), .Z80_OFFS(22'h000000), .PCM0_OFFS(22'h020000), .PCM1_OFFS(22'h120000)
    ) dut (
        .CLK96(CLK96), .RESET96(RESET96),
        .Z80_CS(Z80_CS), .Z80_ADDR(Z80_ADDR), .Z80_OK(Z80_OK), .Z80_DOUT(Z80_DOUT),
        .PCM0_CS(PCM0_CS), .PCM0_ADDR(PCM0_ADDR), .PCM0_OK(PCM0_OK), .PCM0_DOUT(PCM0_DOUT),
        .PCM1_CS(PCM1_CS), .PCM1_ADDR(PCM1_ADDR), .PCM1_OK(PCM1_OK), .PCM1_DOUT(PCM1_DOUT),
        .SDR_CS(SDR_CS), .SDR_ADDR(SDR_ADDR), .SDR_OK(SDR_OK), .SDR_DATA(SDR_DATA)
    );

    initial CLK96 = 1'b0;
    always #5 CLK96 = ~CLK96;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic tick();
        @(posedge CLK96);
        #1;
    endtask

    // Waits (bounded) for a request, checks its address, then acks on the first WAIT cycle.
    task automatic serve(input string tag, input logic [21:0] exp_addr, input logic [15:0] d);
        int n;
        n = 0;
        while (!SDR_CS && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_cs"}, 32'(SDR_CS), 32'd1);
        check({tag, "_addr"}, 32'(SDR_ADDR), 32'(exp_addr));
        tick();
        SDR_OK   = 1'b1;
        SDR_DATA = d;
        tick();
        SDR_OK = 1'b0;
        #1;
    endtask

    logic [21:0] t4_addr [4];
    int          t4_req  [4];
    logic        ok_sel;

    initial begin
`ifdef BATRIDER_SNDARB_Z80PRIO_EN
        t4_req  = '{0, 0, 0, 0};
        t4_addr = '{22'h000080, 22'h000100, 22'h000180, 22'h000200};
`else
        t4_req  = '{0, 1, 2, 0};
        t4_addr = '{22'h000080, 22'h020080, 22'h120100, 22'h000100};
`endif
        RESET96 = 1'b1;
        Z80_CS = 0; PCM0_CS = 0; PCM1_CS = 0;
        Z80_ADDR = '0; PCM0_ADDR = '0; PCM1_ADDR = '0;
        SDR_OK = 0; SDR_DATA = '0;
        tick(); tick();
        RESET96 = 1'b0;
        #1;
        check("rst_sdr_cs", 32'(SDR_CS), 32'd0);
        check("rst_sdr_addr", 32'(SDR_ADDR), 32'd0);
        check("rst_oks", 32'({Z80_OK, PCM0_OK, PCM1_OK}), 32'd0);

        // Z80 miss on odd byte 5 -> word 2
        Z80_CS = 1; Z80_ADDR = 18'h00005;
        #1 check("z80_miss_ok0", 32'(Z80_OK), 32'd0);
        tick();
        check("z80_grant_cs", 32'(SDR_CS), 32'd1);
        check("z80_grant_addr", 32'(SDR_ADDR), 32'h000002);
        tick();
        SDR_OK = 1; SDR_DATA = 16'hA55A;
        #1 check("z80_wait_ok0", 32'(Z80_OK), 32'd0);
        tick();
        SDR_OK = 0;
        #1;
        check("z80_fill_ok", 32'(Z80_OK), 32'd1);
        check("z80_fill_dout", 32'(Z80_DOUT), 32'hA5);
        check("z80_fill_cs0", 32'(SDR_CS), 32'd0);

        // Same word, even byte: immediate hit
        Z80_ADDR = 18'h00004;
        #1;
        check("z80_hit_ok", 32'(Z80_OK), 32'd1);
        check("z80_hit_dout", 32'(Z80_DOUT), 32'h5A);
        tick();
        check("z80_hit_nocs_a", 32'(SDR_CS), 32'd0);
        tick();
        check("z80_hit_nocs_b", 32'(SDR_CS), 32'd0);

        // Both PCM channels together, rr at PCM0
        Z80_CS = 0;
        PCM0_CS = 1; PCM0_ADDR = 21'h000010;
        PCM1_CS = 1; PCM1_ADDR = 21'h000010;
        #1 check("pcm_both_ok0", 32'({PCM0_OK, PCM1_OK}), 32'd0);
        serve("pcm0_first", 22'h020008, 16'h1122);
        check("pcm0_ok", 32'(PCM0_OK), 32'd1);
        check("pcm0_dout", 32'(PCM0_DOUT), 32'h22);
        check("pcm1_still0", 32'(PCM1_OK), 32'd0);
        serve("pcm1_second", 22'h120008, 16'h3344);
        check("pcm1_ok", 32'(PCM1_OK), 32'd1);
        check("pcm1_dout", 32'(PCM1_DOUT), 32'h44);
        check("pcm0_kept", 32'(PCM0_OK), 32'd1);

        // All three pending, each re-missing after its own fill
        Z80_CS = 1; Z80_ADDR = 18'h00100;
        PCM0_ADDR = 21'h000100;
        PCM1_ADDR = 21'h000200;
        for (int k = 0; k < 4; k++) begin
            serve($sformatf("rr%0d", k), t4_addr[k], 16'(16'h1000 + k));
            case (t4_req[k])
                0:       ok_sel = Z80_OK;
                1:       ok_sel = PCM0_OK;
                default: ok_sel = PCM1_OK;
            endcase
            check($sformatf("rr%0d_ok", k), 32'(ok_sel), 32'd1);
            case (t4_req[k])
                0:       Z80_ADDR  = Z80_ADDR + 18'h100;
                1:       PCM0_ADDR = PCM0_ADDR + 21'h200;
                default: PCM1_ADDR = PCM1_ADDR + 21'h200;
            endcase
        end
        Z80_CS = 0; PCM0_CS = 0; PCM1_CS = 0;
        tick();

        // Stale ack held high from before the request
        RESET96 = 1; tick(); RESET96 = 0;
        SDR_OK = 1; SDR_DATA = 16'hBEEF;
        Z80_CS = 1; Z80_ADDR = 18'h00011;
        #1 check("stale_idle_ok0", 32'(Z80_OK), 32'd0);
        tick();
        check("stale_grant_addr", 32'(SDR_ADDR), 32'h000008);
        tick();
        check("stale_issue_ok0", 32'(Z80_OK), 32'd0);
        check("stale_issue_cs", 32'(SDR_CS), 32'd1);
        tick();
        SDR_OK = 0;
        #1;
        check("stale_fill_ok", 32'(Z80_OK), 32'd1);
        check("stale_fill_dout", 32'(Z80_DOUT), 32'hBE);

        // Reset in WAIT: request drops at once, cache cleared, late ack ignored
        Z80_ADDR = 18'h00021;
        tick();
        check("rstw_grant_addr", 32'(SDR_ADDR), 32'h000010);
        tick();
        SDR_OK = 1; SDR_DATA = 16'h5555;
        Z80_ADDR = 18'h00011;
        RESET96 = 1;
        #1;
        check("rstw_cs0", 32'(SDR_CS), 32'd0);
        check("rstw_ok0", 32'(Z80_OK), 32'd0);
        tick();
        RESET96 = 0;
        #1 check("rstw_post_ok0", 32'(Z80_OK), 32'd0);
        SDR_OK = 0;
        serve("refetch", 22'h000008, 16'hCAFE);
        check("refetch_ok", 32'(Z80_OK), 32'd1);
        check("refetch_dout", 32'(Z80_DOUT), 32'hCA);

        // PCM0 address changes mid-fetch; Z80 hit served meanwhile
        Z80_CS = 0;
        PCM0_CS = 1; PCM0_ADDR = 21'h000040;
        tick();
        check("mid_grant_addr", 32'(SDR_ADDR), 32'h020020);
        PCM0_ADDR = 21'h000050;
        tick();
        Z80_CS = 1; Z80_ADDR = 18'h00011;
        #1;
        check("mid_z80_hit", 32'(Z80_OK), 32'd1);
        check("mid_z80_dout", 32'(Z80_DOUT), 32'hCA);
        SDR_OK = 1; SDR_DATA = 16'h7788;
        tick();
        SDR_OK = 0;
        #1 check("mid_old_fill_ok0", 32'(PCM0_OK), 32'd0);
        Z80_CS = 0;
        serve("mid_refetch", 22'h020028, 16'h99AA);
        check("mid_new_ok", 32'(PCM0_OK), 32'd1);
        check("mid_new_dout", 32'(PCM0_DOUT), 32'hAA);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
